// File: rtl/add_serial_ctrl.sv
// Purpose : sequencer and result collector for the bit-serial adder add_serial.
// Latency : op accepted at edge N -> res_valid after edge N+LAT+3 (idle, empty FIFO); one op per LAT+4 cycles.
// Backpressure: op_ready = !full; a held result stalls the FSM in CAPTURE while the adder holds its sum.
//
// Ports:
//   clk, rst             clock (rising edge) and async active-high reset, shared with the adder
//   op_valid/op_ready    operand stream in, op_a/op_b operands
//   add_en/add_a/add_b   adder enable (polarity by EN_ACTIVE_LOW) and pre-masked operands
//   add_out              adder parallel result
//   res_valid/res_ready  result stream out, res_sum = (op_a + op_b) mod 2^WIDTH
//   busy                 FSM not idle
module add_serial_ctrl #(
   parameter int               WIDTH         = 8,
   parameter int               DEPTH         = 2,
   parameter int               LAT           = 8,
   parameter bit               EN_ACTIVE_LOW = 1'b1,
   parameter logic [WIDTH-1:0] A_MASK        = 8'hA9,
   parameter logic [WIDTH-1:0] B_MASK        = 8'h51
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             add_en,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   localparam logic EN_ON  = EN_ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam logic EN_OFF = ~EN_ON;

   localparam logic [AW:0]   PTR_ONE  = 1;
   localparam logic [CW-1:0] CNT_ONE  = 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_CAPTURE,
      S_RELEASE
   } state_t;

   state_t state;

   // ------------------------------------------------------------------
   // Operand FIFO. Pointers carry one extra wrap bit so full and empty
   // are distinguishable with DEPTH a power of two.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             fifo_empty;
   logic             fifo_full;
   logic             push;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign op_ready   = ~fifo_full;
   assign push       = op_valid & op_ready;

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr[AW-1:0]] <= op_a;
         mem_b[wr_ptr[AW-1:0]] <= op_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PTR_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Sequencer. The read pointer lives here because the pop is the
   // IDLE -> LAUNCH transition itself.
   // ------------------------------------------------------------------
   logic [CW-1:0] cnt;

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rd_ptr    <= '0;
         cnt       <= '0;
         add_en    <= EN_OFF;
         add_a     <= '0;
         add_b     <= '0;
         res_valid <= 1'b0;
         res_sum   <= '0;
      end else begin
         // Accepted result drops; a CAPTURE reload below overrides this.
         if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  // Pre-invert the bits the adder inverts so it sums true operands.
                  add_a  <= mem_a[rd_ptr[AW-1:0]] ^ A_MASK;
                  add_b  <= mem_b[rd_ptr[AW-1:0]] ^ B_MASK;
                  rd_ptr <= rd_ptr + PTR_ONE;
                  add_en <= EN_ON;
                  state  <= S_LAUNCH;
               end
            end

            S_LAUNCH: begin
               // The adder samples add_a/add_b at the end of this cycle.
               add_en <= EN_OFF;
               cnt    <= CNT_INIT;
               state  <= S_WAIT;
            end

            S_WAIT: begin
               if (cnt == '0) begin
                  state <= S_CAPTURE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            S_CAPTURE: begin
               // The adder holds its sum while done, so waiting here for the
               // output register to free up loses nothing.
               if (!res_valid || res_ready) begin
                  res_sum   <= add_out;
                  res_valid <= 1'b1;
                  add_en    <= EN_ON;
                  state     <= S_RELEASE;
               end
            end

            S_RELEASE: begin
               // Enable pulse in this cycle returns the adder to idle.
               add_en <= EN_OFF;
               state  <= S_IDLE;
            end

            default: begin
               add_en <= EN_OFF;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Purpose : directed bench for add_serial_ctrl with a cycle model of the bit-serial adder.
// Latency : result expected LAT+4 edges after the push edge when idle (handshake edge).
// Backpressure: res_ready is held low in one scenario to stall the controller.
module tb_add_serial_ctrl;

   localparam int LAT = 8;

   localparam logic [1:0] M_IDLE = 2'd0;
   localparam logic [1:0] M_RUN  = 2'd1;
   localparam logic [1:0] M_DONE = 2'd2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       op_valid = 1'b0;
   logic [7:0] op_a = 8'h00;
   logic [7:0] op_b = 8'h00;
   logic       res_ready = 1'b1;

   logic       op_ready0, op_ready1, add_en0, add_en1;
   logic       res_valid0, res_valid1, busy0, busy1;
   logic [7:0] add_a0, add_b0, add_out0, res_sum0;
   logic [7:0] add_a1, add_b1, add_out1, res_sum1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // dut0: default active-low enable; dut1: active-high enable, same stimulus.
   add_serial_ctrl dut0 (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_ready(op_ready0), .op_a(op_a), .op_b(op_b),
      .add_en(add_en0), .add_a(add_a0), .add_b(add_b0), .add_out(add_out0),
      .res_valid(res_valid0), .res_ready(res_ready), .res_sum(res_sum0),
      .busy(busy0)
   );

   add_serial_ctrl #(.EN_ACTIVE_LOW(1'b0)) dut1 (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_ready(op_ready1), .op_a(op_a), .op_b(op_b),
      .add_en(add_en1), .add_a(add_a1), .add_b(add_b1), .add_out(add_out1),
      .res_valid(res_valid1), .res_ready(res_ready), .res_sum(res_sum1),
      .busy(busy1)
   );

   // ---------------- adder model (one per DUT) ----------------
   logic       en_act [2];
   logic [7:0] aa [2];
   logic [7:0] ab [2];
   logic [1:0] m_st [2]  = '{M_IDLE, M_IDLE};
   int         m_k [2]   = '{0, 0};
   logic [7:0] m_sum [2] = '{8'h00, 8'h00};
   logic [7:0] m_a [2]   = '{8'h00, 8'h00};
   logic [7:0] m_b [2]   = '{8'h00, 8'h00};
   int         m_err [2] = '{0, 0};

   assign en_act[0] = ~add_en0;
   assign en_act[1] = add_en1;
   assign aa[0] = add_a0;
   assign aa[1] = add_a1;
   assign ab[0] = add_b0;
   assign ab[1] = add_b1;

   // Output is wrong until LAT edges after the launch edge, then the true sum.
   assign add_out0 = (m_st[0] == M_DONE) ? m_sum[0] : ~m_sum[0];
   assign add_out1 = (m_st[1] == M_DONE) ? m_sum[1] : ~m_sum[1];

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_st[i] <= M_IDLE;
            m_k[i]  <= 0;
         end else begin
            case (m_st[i])
               M_IDLE: if (en_act[i]) begin
                  m_a[i]   <= aa[i];
                  m_b[i]   <= ab[i];
                  m_sum[i] <= (aa[i] ^ 8'hA9) + (ab[i] ^ 8'h51);
                  m_k[i]   <= 0;
                  m_st[i]  <= M_RUN;
               end
               M_RUN: begin
                  if (en_act[i] || aa[i] !== m_a[i] || ab[i] !== m_b[i])
                     m_err[i] <= m_err[i] + 1;
                  m_k[i] <= m_k[i] + 1;
                  if (m_k[i] + 1 == LAT) m_st[i] <= M_DONE;
               end
               M_DONE: begin
                  if (aa[i] !== m_a[i] || ab[i] !== m_b[i])
                     m_err[i] <= m_err[i] + 1;
                  if (en_act[i]) m_st[i] <= M_IDLE;
               end
               default: m_st[i] <= M_IDLE;
            endcase
         end
      end
   end

   // ---------------- monitor ----------------
   int         cyc = 0;
   int         en_cnt0 = 0;
   int         proto = 0;
   logic       prev0 = 1'b0;
   logic       prev1 = 1'b0;
   logic [7:0] rq0 [$];
   logic [7:0] rq1 [$];
   int         rt0 [$];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         if (res_valid0 && res_ready) begin
            rq0.push_back(res_sum0);
            rt0.push_back(cyc);
         end
         if (res_valid1 && res_ready) rq1.push_back(res_sum1);
         if (en_act[0]) en_cnt0 = en_cnt0 + 1;
         if (en_act[0] && prev0) proto = proto + 1;
         if (en_act[1] && prev1) proto = proto + 1;
         if (en_act[0] != en_act[1]) proto = proto + 1;
         prev0 = en_act[0];
         prev1 = en_act[1];
      end else begin
         prev0 = 1'b0;
         prev1 = 1'b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      int n;
      n = 0;
      op_valid = 1'b1;
      op_a = a;
      op_b = b;
      while (!op_ready0 && n < 60) begin
         tick();
         n++;
      end
      check("push_ready", op_ready0, 1);
      tick();
      op_valid = 1'b0;
   endtask

   task automatic wait_res(input int n);
      int k;
      k = 0;
      while (rq0.size() < n && k < 200) begin
         tick();
         k++;
      end
      check("wait_res", rq0.size(), n);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t0;
      int e0;
      int k;

      // Reset state
      tick(); tick(); tick();
      check("rst_op_ready", op_ready0, 1);
      check("rst_res_valid", res_valid0, 0);
      check("rst_res_sum", res_sum0, 8'h00);
      check("rst_add_a", add_a0, 8'h00);
      check("rst_add_b", add_b0, 8'h00);
      check("rst_busy", busy0, 0);
      check("rst_en_low", add_en0, 1);
      check("rst_en_high", add_en1, 0);
      rst = 1'b0;
      tick(); tick();

      // 1. single op 35 + 4A
      e0 = en_cnt0;
      push(8'h35, 8'h4A);
      t0 = cyc;
      tick();
      check("s1_add_a", add_a0, 8'h9C);
      check("s1_add_b", add_b0, 8'h1B);
      check("s1_en_launch_low", add_en0, 0);
      check("s1_en_launch_high", add_en1, 1);
      check("s1_busy", busy0, 1);
      tick();
      check("s1_en_wait", add_en0, 1);
      wait_res(1);
      check("s1_sum", rq0[0], 8'h7F);
      check("s1_sum_pol", rq1[0], 8'h7F);
      check("s1_latency", rt0[0] - t0, LAT + 4);
      check("s1_valid_drop", res_valid0, 0);
      tick(); tick();
      check("s1_one_result", rq0.size(), 1);
      check("s1_en_pulses", en_cnt0 - e0, 2);

      // 2. overflow cases
      push(8'hFF, 8'h01);
      push(8'h80, 8'h80);
      push(8'h7F, 8'h01);
      wait_res(4);
      check("s2_ff_01", rq0[1], 8'h00);
      check("s2_80_80", rq0[2], 8'h00);
      check("s2_7f_01", rq0[3], 8'h80);
      check("s2_pol_7f_01", rq1[3], 8'h80);

      // 3. back-to-back, FIFO fills
      tick(); tick();
      push(8'd10, 8'd20);
      t0 = cyc;
      push(8'd1, 8'd2);
      push(8'd200, 8'd100);
      check("s3_full", op_ready0, 0);
      repeat (5) tick();
      check("s3_full_held", op_ready0, 0);
      k = 0;
      while (!op_ready0 && k < 40) begin
         tick();
         k++;
      end
      check("s3_ready_return", cyc - t0, 13);
      wait_res(7);
      check("s3_r0", rq0[4], 8'd30);
      check("s3_r1", rq0[5], 8'd3);
      check("s3_r2", rq0[6], 8'd44);
      check("s3_pol_r2", rq1[6], 8'd44);
      check("s3_first_lat", rt0[4] - t0, LAT + 4);
      check("s3_space1", rt0[5] - rt0[4], LAT + 4);
      check("s3_space2", rt0[6] - rt0[5], LAT + 4);

      // 4. backpressure: two ops complete while res_ready is low
      tick(); tick();
      res_ready = 1'b0;
      push(8'h12, 8'h34);
      push(8'hF0, 8'h20);
      repeat (30) tick();
      check("s4_valid_held", res_valid0, 1);
      check("s4_sum_held", res_sum0, 8'h46);
      check("s4_stall_busy", busy0, 1);
      check("s4_stall_en", add_en0, 1);
      check("s4_none_taken", rq0.size(), 7);
      repeat (5) tick();
      check("s4_sum_stable", res_sum0, 8'h46);
      check("s4_pol_sum", res_sum1, 8'h46);
      res_ready = 1'b1;
      tick();
      check("s4_reload_valid", res_valid0, 1);
      check("s4_reload_sum", res_sum0, 8'h10);
      tick();
      check("s4_drained", res_valid0, 0);
      check("s4_idle", busy0, 0);
      check("s4_r0", rq0[7], 8'h46);
      check("s4_r1", rq0[8], 8'h10);
      check("s4_pol_r1", rq1[8], 8'h10);
      check("s4_back_to_back", rt0[8] - rt0[7], 1);

      // 5. reset 4 cycles after LAUNCH with one op still queued
      tick(); tick();
      push(8'h55, 8'h11);
      push(8'h66, 8'h77);
      repeat (4) tick();
      check("s5_busy_pre", busy0, 1);
      rst = 1'b1;
      #1;
      check("s5_rst_valid", res_valid0, 0);
      check("s5_rst_sum", res_sum0, 8'h00);
      check("s5_rst_add_a", add_a0, 8'h00);
      check("s5_rst_add_b", add_b0, 8'h00);
      check("s5_rst_en_low", add_en0, 1);
      check("s5_rst_en_high", add_en1, 0);
      check("s5_rst_busy", busy0, 0);
      check("s5_rst_ready", op_ready0, 1);
      tick();
      rst = 1'b0;
      repeat (20) tick();
      check("s5_fifo_flushed", busy0, 0);
      check("s5_no_partial", rq0.size(), 9);
      push(8'h11, 8'h22);
      wait_res(10);
      check("s5_sum", rq0[9], 8'h33);
      check("s5_pol_sum", rq1[9], 8'h33);

      // Adder protocol and enable polarity over the whole run
      tick(); tick();
      check("adder_proto_low", m_err[0], 0);
      check("adder_proto_high", m_err[1], 0);
      check("en_pulse_proto", proto, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
